// File: rtl/wb_lock_arbiter_pkg.sv
// Shared definitions for the locking Wishbone arbiter.
// - Bus widths for address, data and byte-select.
// - Two-state arbiter FSM encoding.
package wb_lock_arbiter_pkg;

  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StGranted = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker.
// Searches last_i+1, last_i+2, ... (mod N) and returns the first requester.
// Ports:
//   req_i   N     request vector
//   last_i  IdxW  index of the previous owner (lowest priority this round)
//   gnt_o   N     one-hot grant, all zero when no request
//   idx_o   IdxW  index of the granted requester (0 when none)
module wb_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic            w_found;
  logic [IdxW-1:0] w_cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_cand = IdxW'((32'(last_i) + i) % N);
      if (!w_found && req_i[w_cand]) begin
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_lock_arbiter.sv
// N-master to 1-slave Wishbone arbiter that holds the grant for the whole cyc
// window, so a read+write pair under one cyc stays atomic. Round-robin between
// masters, one IDLE cycle between grants, optional watchdog that answers a hung
// strobe with err.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i   packed master request fields, master k at slice k
//   m_we_i/m_cyc_i/m_stb_i    per-master control
//   m_dat_o                   slave read data broadcast to every master
//   m_ack_o/m_err_o/m_rty_o   responses, only the granted bit can be set
//   s_*_o                     slave-side request (pass-through of the owner)
//   s_dat_i/s_ack_i/...       slave response
//   grant_o                   registered one-hot grant
module wb_lock_arbiter
  import wb_lock_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_MASTERS*WB_AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*WB_DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*WB_SELW-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS-1:0]         m_cyc_i,
  input  logic [NUM_MASTERS-1:0]         m_stb_i,
  output logic [WB_DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  output logic [NUM_MASTERS-1:0]         m_err_o,
  output logic [NUM_MASTERS-1:0]         m_rty_o,
  output logic [WB_AW-1:0]               s_adr_o,
  output logic [WB_DW-1:0]               s_dat_o,
  output logic [WB_SELW-1:0]             s_sel_o,
  output logic                           s_we_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  input  logic [WB_DW-1:0]               s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  input  logic                           s_rty_i,
  output logic [NUM_MASTERS-1:0]         grant_o
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             r_state, w_state_d;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_d;
  logic [IdxW-1:0]        r_gidx, w_gidx_d;
  logic [IdxW-1:0]        r_last, w_last_d;
  logic [31:0]            r_wdog, w_wdog_d;

  logic [NUM_MASTERS-1:0] w_rr_gnt;
  logic [IdxW-1:0]        w_rr_idx;

  logic [WB_AW-1:0]       w_adr;
  logic [WB_DW-1:0]       w_dat;
  logic [WB_SELW-1:0]     w_sel;
  logic                   w_we, w_cyc, w_stb;
  logic                   w_resp, w_busy, w_fire;

  wb_rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr (
    .req_i  (m_cyc_i),
    .last_i (r_last),
    .gnt_o  (w_rr_gnt),
    .idx_o  (w_rr_idx)
  );

  // Select the owner's request fields by index.
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_we  = 1'b0;
    w_cyc = 1'b0;
    w_stb = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (r_gidx == IdxW'(k)) begin
        w_adr = m_adr_i[k*WB_AW +: WB_AW];
        w_dat = m_dat_i[k*WB_DW +: WB_DW];
        w_sel = m_sel_i[k*WB_SELW +: WB_SELW];
        w_we  = m_we_i[k];
        w_cyc = m_cyc_i[k];
        w_stb = m_stb_i[k];
      end
    end
  end

  assign w_resp = s_ack_i | s_err_i | s_rty_i;
  // A strobe the slave has not yet answered.
  assign w_busy = (r_state == StGranted) && w_cyc && w_stb && !w_resp;
  assign w_fire = (TIMEOUT != 0) && w_busy && (r_wdog == 32'(TIMEOUT - 1));

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_gidx_d  = r_gidx;
    w_last_d  = r_last;
    w_wdog_d  = '0;
    unique case (r_state)
      StIdle: begin
        if (|m_cyc_i) begin
          w_state_d = StGranted;
          w_grant_d = w_rr_gnt;
          w_gidx_d  = w_rr_idx;
        end
      end
      StGranted: begin
        if (w_busy && !w_fire) begin
          w_wdog_d = (r_wdog == '1) ? r_wdog : r_wdog + 32'd1;
        end
        // Ownership ends only when the owner drops cyc; stb gaps keep the lock.
        if (!w_cyc) begin
          w_state_d = StIdle;
          w_grant_d = '0;
          w_last_d  = r_gidx;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IdxW'(NUM_MASTERS - 1);
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_gidx  <= w_gidx_d;
      r_last  <= w_last_d;
      r_wdog  <= w_wdog_d;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (r_state == StGranted) begin
      s_adr_o         = w_adr;
      s_dat_o         = w_dat;
      s_sel_o         = w_sel;
      s_we_o          = w_we;
      s_cyc_o         = w_cyc;
      s_stb_o         = w_cyc && w_stb && !w_fire;
      m_ack_o[r_gidx] = s_ack_i;
      m_err_o[r_gidx] = s_err_i | w_fire;
      m_rty_o[r_gidx] = s_rty_i;
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_lock_arbiter.sv
// Bench for wb_lock_arbiter: directed scenarios with literal expectations, then
// randomized masters and slave checked every cycle against an ownership model.
module tb_wb_lock_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [127:0]  m_adr, m_dat;
  logic [15:0]   m_sel;
  logic [3:0]    m_we, m_cyc, m_stb;
  logic [31:0]   m_dat_o;
  logic [3:0]    m_ack_o, m_err_o, m_rty_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic [31:0]   s_dat;
  logic          s_ack, s_err, s_rty;
  logic [3:0]    grant_o;

  always #5 clk = ~clk;

  wb_lock_arbiter #(
    .NUM_MASTERS (N),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_we_i  (m_we),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .s_rty_i (s_rty),
    .grant_o (grant_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ownership model: who holds the bus, who held it last, how long the
  // current strobe has waited without an answer.
  int mo_owner = -1;
  int mo_last  = N - 1;
  int mo_run   = 0;

  function automatic bit model_fire();
    int o;
    o = mo_owner;
    if (o < 0) return 1'b0;
    return m_cyc[o] && m_stb[o] && !(s_ack || s_err || s_rty) && (mo_run == TO - 1);
  endfunction

  always @(posedge clk) begin
    bit f, waiting, found;
    int c;
    if (rst_i) begin
      mo_owner = -1;
      mo_last  = N - 1;
      mo_run   = 0;
    end else if (mo_owner < 0) begin
      mo_run = 0;
      found  = 1'b0;
      for (int i = 1; i <= N; i++) begin
        c = (mo_last + i) % N;
        if (!found && m_cyc[c]) begin
          mo_owner = c;
          found    = 1'b1;
        end
      end
    end else begin
      f       = model_fire();
      waiting = m_cyc[mo_owner] && m_stb[mo_owner] && !(s_ack || s_err || s_rty);
      mo_run  = (waiting && !f) ? mo_run + 1 : 0;
      if (!m_cyc[mo_owner]) begin
        mo_last  = mo_owner;
        mo_owner = -1;
      end
    end
  end

  logic [3:0]  e_grant, e_ack, e_err, e_rty, e_sel;
  logic [31:0] e_adr, e_wdat;
  logic        e_cyc, e_stb, e_we;

  always @(negedge clk) begin
    bit f;
    if (cmp_on) begin
      e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_sel = '0;
      e_adr = '0; e_wdat = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      f = model_fire();
      if (mo_owner >= 0) begin
        e_grant[mo_owner] = 1'b1;
        e_cyc             = m_cyc[mo_owner];
        e_stb             = m_cyc[mo_owner] && m_stb[mo_owner] && !f;
        e_adr             = m_adr[mo_owner*32 +: 32];
        e_wdat            = m_dat[mo_owner*32 +: 32];
        e_sel             = m_sel[mo_owner*4 +: 4];
        e_we              = m_we[mo_owner];
        e_ack[mo_owner]   = s_ack;
        e_err[mo_owner]   = s_err || f;
        e_rty[mo_owner]   = s_rty;
      end
      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
      chk("s_stb", 32'(s_stb_o), 32'(e_stb));
      chk("s_adr", s_adr_o, e_adr);
      chk("s_dat", s_dat_o, e_wdat);
      chk("s_sel", 32'(s_sel_o), 32'(e_sel));
      chk("s_we", 32'(s_we_o), 32'(e_we));
      chk("m_ack", 32'(m_ack_o), 32'(e_ack));
      chk("m_err", 32'(m_err_o), 32'(e_err));
      chk("m_rty", 32'(m_rty_o), 32'(e_rty));
      chk("m_dat", m_dat_o, s_dat);
    end
  end

  task automatic set_req(input int k, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat);
    m_cyc[k]           = 1'b1;
    m_stb[k]           = 1'b1;
    m_we[k]            = we;
    m_adr[k*32 +: 32]  = adr;
    m_dat[k*32 +: 32]  = dat;
    m_sel[k*4 +: 4]    = 4'hF;
  endtask

  int  exp_seq [14] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 0};
  bit  got [N];
  int  ph [N], ops [N], gap [N], wt [N];
  int  pend;

  task automatic new_req(input int k);
    m_adr[k*32 +: 32] = $urandom;
    m_dat[k*32 +: 32] = $urandom;
    m_sel[k*4 +: 4]   = 4'($urandom);
    m_we[k]           = 1'($urandom);
  endtask

  task automatic agent_step(input int k);
    case (ph[k])
      0: if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          m_cyc[k] = 1'b1;
          m_stb[k] = 1'b0;
          ph[k]    = 3;
        end else begin
          new_req(k);
          m_cyc[k] = 1'b1;
          m_stb[k] = 1'b1;
          ops[k]   = $urandom_range(1, 3);
          wt[k]    = 0;
          ph[k]    = 1;
        end
      end
      1: if (got[k]) begin
        wt[k] = 0;
        ops[k]--;
        if (ops[k] == 0) begin
          m_cyc[k] = 1'b0;
          m_stb[k] = 1'b0;
          ph[k]    = 0;
        end else begin
          m_stb[k] = 1'b0;
          gap[k]   = $urandom_range(0, 3);
          ph[k]    = 2;
        end
      end else begin
        wt[k]++;
        if (wt[k] > 400) begin
          n_cmp++;
          n_bad++;
          $display("FAIL starve master %0d: waited %0d cycles, limit 400", k, wt[k]);
          m_cyc[k] = 1'b0;
          m_stb[k] = 1'b0;
          ph[k]    = 0;
        end
      end
      2: if (gap[k] == 0) begin
        new_req(k);
        m_stb[k] = 1'b1;
        ph[k]    = 1;
      end else begin
        gap[k]--;
      end
      default: begin
        m_cyc[k] = 1'b0;
        ph[k]    = 0;
      end
    endcase
  endtask

  task automatic slave_step();
    int r;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    s_dat = $urandom;
    if (s_cyc_o && s_stb_o) begin
      if (pend < 0) pend = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 3);
      if (pend == 0) begin
        r = $urandom_range(0, 9);
        s_ack = (r < 8);
        s_err = (r == 8);
        s_rty = (r == 9);
        pend  = -1;
      end else begin
        pend--;
      end
    end else begin
      pend = -1;
      if (!s_cyc_o && $urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 2);
        s_ack = (r == 0);
        s_err = (r == 1);
        s_rty = (r == 2);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    for (int k = 0; k < N; k++) got[k] = 1'b0;
    tick();
    cmp_on = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_s_cyc", 32'(s_cyc_o), 0);
    chk("rst_s_stb", 32'(s_stb_o), 0);
    chk("rst_m_ack", 32'(m_ack_o), 0);

    // Stray responses while idle must not reach any master.
    tick();
    s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1; s_dat = 32'h1234_5678;
    @(negedge clk);
    chk("stray_ack", 32'(m_ack_o), 0);
    chk("stray_err", 32'(m_err_o), 0);
    chk("stray_rty", 32'(m_rty_o), 0);
    tick();
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // All four request together: 0,1,2,3 with one idle cycle between grants.
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 0) for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'(k * 16), 32'(k));
      for (int k = 0; k < N; k++) if (got[k]) begin m_cyc[k] = 1'b0; m_stb[k] = 1'b0; end
      #1;
      s_ack = s_stb_o;
      @(negedge clk);
      chk($sformatf("rr_order_c%0d", c), 32'(grant_o), 32'(exp_seq[c]));
      for (int k = 0; k < N; k++) got[k] = m_ack_o[k];
    end
    s_ack = 1'b0;
    for (int k = 0; k < N; k++) got[k] = 1'b0;

    // Single read by master 0, slave answers in its second strobe cycle.
    tick();
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    chk("rd_grant_c0", 32'(grant_o), 0);
    tick();
    @(negedge clk);
    chk("rd_grant_c1", 32'(grant_o), 32'h1);
    chk("rd_stb_c1", 32'(s_stb_o), 1);
    tick();
    s_ack = 1'b1; s_dat = 32'hCAFE_0001;
    @(negedge clk);
    chk("rd_ack", 32'(m_ack_o), 32'h1);
    chk("rd_dat", m_dat_o, 32'hCAFE_0001);
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    chk("rd_release_cyc", 32'(s_cyc_o), 0);
    tick();
    @(negedge clk);
    chk("rd_idle_grant", 32'(grant_o), 0);

    // CAS by master 1 while master 2 waits.
    for (int c = 0; c < 12; c++) begin
      tick();
      case (c)
        0: begin
          set_req(1, 1'b0, 32'h7FFF_FFFC, 32'h0);
          set_req(2, 1'b0, 32'h0000_2000, 32'h0);
        end
        2: m_stb[1] = 1'b0;
        5: begin
          m_stb[1] = 1'b1;
          m_we[1]  = 1'b1;
          m_dat[32 +: 32] = 32'h0000_0001;
        end
        6: begin
          m_cyc[1] = 1'b0;
          m_stb[1] = 1'b0;
        end
        default: ;
      endcase
      if (got[2]) begin m_cyc[2] = 1'b0; m_stb[2] = 1'b0; end
      #1;
      s_ack = s_stb_o;
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        chk($sformatf("cas_lock_c%0d", c), 32'(grant_o), 32'h2);
        chk($sformatf("cas_m2_ack_c%0d", c), 32'(m_ack_o[2]), 0);
      end
      if (c == 7) chk("cas_bubble", 32'(grant_o), 0);
      if (c == 8) chk("cas_next", 32'(grant_o), 32'h4);
      for (int k = 0; k < N; k++) got[k] = m_ack_o[k];
    end
    s_ack = 1'b0;
    for (int k = 0; k < N; k++) got[k] = 1'b0;

    // Watchdog: slave never answers master 0.
    tick();
    set_req(0, 1'b0, 32'h0000_0400, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 9) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      @(negedge clk);
      if (c <= 7) chk($sformatf("wdog_quiet_c%0d", c), 32'(m_err_o), 0);
      if (c == 8) begin
        chk("wdog_err", 32'(m_err_o), 32'h1);
        chk("wdog_stb_low", 32'(s_stb_o), 0);
      end
      if (c == 10) chk("wdog_release", 32'(grant_o), 0);
    end

    // Reset while master 3 owns the bus.
    tick();
    set_req(3, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("rst_mid_grant", 32'(grant_o), 32'h8);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'(k * 4), 32'h0);
    @(negedge clk);
    chk("rst_mid_s_cyc", 32'(s_cyc_o), 0);
    chk("rst_mid_grant0", 32'(grant_o), 0);
    tick();
    @(negedge clk);
    chk("rst_mid_restart", 32'(grant_o), 32'h1);
    tick();
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    // Randomized traffic.
    pend = -1;
    for (int k = 0; k < N; k++) begin ph[k] = 0; got[k] = 1'b0; end
    for (int cy = 0; cy < 5000; cy++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        rst_i = 1'b1;
        m_cyc = '0; m_stb = '0;
        for (int k = 0; k < N; k++) ph[k] = 0;
      end else begin
        rst_i = 1'b0;
        for (int k = 0; k < N; k++) agent_step(k);
      end
      #1;
      slave_step();
      @(negedge clk);
      for (int k = 0; k < N; k++) got[k] = m_ack_o[k] | m_err_o[k] | m_rty_o[k];
    end
    tick();
    rst_i = 1'b0;
    m_cyc = '0; m_stb = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    tick();
    tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
